// File: rtl/adc_if_pkg.sv
// Shared tap width default, FSM encoding and width helper for the ADC
// lane deskew calibrator and its window tracker.
package adc_if_pkg;

    localparam int TAP_W_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_APPLY,
        ST_SETTLE2,
        ST_DONE
    } cal_state_e;

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_window_tracker.sv
// Follows one lane's tap sweep and keeps the widest run of passing taps;
// the earliest window wins ties. Cleared before every lane.
module adc_window_tracker
    import adc_if_pkg::*;
#(
    parameter int TAP_W = TAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             eval,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre
);

    logic [TAP_W:0]   cur_len_q, cur_len_d, best_len_q, best_len_d, len_m1;
    logic [TAP_W-1:0] cur_start_q, cur_start_d, best_start_q, best_start_d;

    always_comb begin
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (clear) begin
            cur_len_d    = '0;
            cur_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
        end else if (eval) begin
            if (pass) begin
                cur_len_d = cur_len_q + 1'b1;
                if (cur_len_q == '0)
                    cur_start_d = tap;
            end else begin
                cur_len_d = '0;
            end
            // Strictly greater keeps the first of several equal windows.
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

    assign len_m1   = best_len_q - 1'b1;
    assign best_len = best_len_q;
    assign centre   = best_start_q + TAP_W'(len_m1 >> 1);

endmodule

// File: rtl/adc_lane_deskew.sv
// Per-lane IDELAY tap sweep against the ADC test pattern; loads the centre
// of each lane's widest passing window into its delay line.
module adc_lane_deskew
    import adc_if_pkg::*;
#(
    parameter int NUM_LANES   = 8,
    parameter int TAP_W       = TAP_W_DEF,
    parameter int SETTLE_CYC  = 4,
    parameter int DWELL       = 64,
    parameter int MIN_WIN     = 4,
    parameter int DEFAULT_TAP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_LANES-1:0]       data_rise,
    input  logic [NUM_LANES-1:0]       data_fall,
    input  logic [NUM_LANES-1:0]       exp_rise,
    input  logic [NUM_LANES-1:0]       exp_fall,
    output logic [NUM_LANES-1:0]       delay_ld,
    output logic [TAP_W-1:0]           delay_wdata,
    output logic [NUM_LANES*TAP_W-1:0] tap_out,
    output logic [NUM_LANES-1:0]       lane_fail,
    output logic                       busy,
    output logic                       done
);

    localparam int LANE_W  = width_of(NUM_LANES);
    localparam int CNT_MAX = (DWELL > SETTLE_CYC) ? DWELL : SETTLE_CYC;
    localparam int CNT_W   = width_of(CNT_MAX);

    cal_state_e                 state_q, state_d;
    logic [LANE_W-1:0]          lane_q, lane_d;
    logic [TAP_W-1:0]           tap_q, tap_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [NUM_LANES-1:0]       delay_ld_q, delay_ld_d;
    logic [TAP_W-1:0]           delay_wdata_q, delay_wdata_d;
    logic [NUM_LANES*TAP_W-1:0] tap_out_q, tap_out_d;
    logic [NUM_LANES-1:0]       lane_fail_q, lane_fail_d;
    logic                       busy_q, busy_d, done_q, done_d;

    logic [NUM_LANES-1:0] lane_mis, lane_onehot;
    logic                 trk_clear, trk_eval, win_short;
    logic [TAP_W:0]       best_len;
    logic [TAP_W-1:0]     centre, apply_tap;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_mis
            assign lane_mis[gi] = (data_rise[gi] ^ exp_rise[gi]) | (data_fall[gi] ^ exp_fall[gi]);
        end
    endgenerate

    assign lane_onehot = NUM_LANES'(1) << lane_q;
    assign win_short   = best_len < (TAP_W+1)'(MIN_WIN);
    assign apply_tap   = win_short ? TAP_W'(DEFAULT_TAP) : centre;
    assign trk_eval    = (state_q == ST_EVAL);

    adc_window_tracker #(.TAP_W(TAP_W)) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .clear    (trk_clear),
        .eval     (trk_eval),
        .pass     (~err_q),
        .tap      (tap_q),
        .best_len (best_len),
        .centre   (centre)
    );

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        tap_d         = tap_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        delay_ld_d    = '0;
        delay_wdata_d = delay_wdata_q;
        tap_out_d     = tap_out_q;
        lane_fail_d   = lane_fail_q;
        busy_d        = busy_q;
        done_d        = done_q;
        trk_clear     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    lane_d      = '0;
                    tap_d       = '0;
                    lane_fail_d = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    trk_clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                delay_wdata_d = tap_q;
                delay_ld_d    = lane_onehot;
                err_d         = 1'b0;
                cnt_d         = '0;
                state_d       = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                err_d = err_q | lane_mis[lane_q];
                if (cnt_q == CNT_W'(DWELL-1))
                    state_d = ST_EVAL;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_EVAL: begin
                if (tap_q == '1) begin
                    state_d = ST_APPLY;
                end else begin
                    tap_d   = tap_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_APPLY: begin
                tap_out_d[lane_q*TAP_W +: TAP_W] = apply_tap;
                if (win_short)
                    lane_fail_d[lane_q] = 1'b1;
                delay_wdata_d = apply_tap;
                delay_ld_d    = lane_onehot;
                cnt_d         = '0;
                state_d       = ST_SETTLE2;
            end
            ST_SETTLE2: begin
                if (cnt_q == CNT_W'(SETTLE_CYC-1)) begin
                    if (lane_q == LANE_W'(NUM_LANES-1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        lane_d    = lane_q + 1'b1;
                        tap_d     = '0;
                        trk_clear = 1'b1;
                        state_d   = ST_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            lane_q        <= '0;
            tap_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            delay_ld_q    <= '0;
            delay_wdata_q <= '0;
            tap_out_q     <= '0;
            lane_fail_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            tap_q         <= tap_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            delay_ld_q    <= delay_ld_d;
            delay_wdata_q <= delay_wdata_d;
            tap_out_q     <= tap_out_d;
            lane_fail_q   <= lane_fail_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign delay_ld    = delay_ld_q;
    assign delay_wdata = delay_wdata_q;
    assign tap_out     = tap_out_q;
    assign lane_fail   = lane_fail_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_adc_lane_deskew.sv
// Directed bench: a per-lane IODELAY/ADC model returns pass/fail per tap from a
// mask, and the calibrated taps, flags and latency are checked per scenario.
module tb_adc_lane_deskew;

    localparam int NL  = 8;
    localparam int TW  = 5;
    localparam int LAT = NL * ((1 << TW) * (2 + 4 + 64) + 1 + 4) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NL-1:0] data_rise, data_fall;
    logic [NL-1:0] exp_rise = 8'hA5;
    logic [NL-1:0] exp_fall = 8'h3C;
    logic [NL-1:0] delay_ld, lane_fail;
    logic [TW-1:0] delay_wdata;
    logic [NL*TW-1:0] tap_out;
    logic          busy, done;

    int total = 0;
    int bad   = 0;

    logic [31:0]   mask [NL] = '{default: 32'hFFFF_FFFF};
    logic [TW-1:0] cur_tap [NL] = '{default: '0};
    int            scnt [NL] = '{default: 0};
    int            ld_cnt [NL] = '{default: 0};
    int            onehot_bad = 0;
    int            hold_bad = 0;
    logic [NL-1:0] prev_ld = '0;
    logic          inj_en = 1'b0;
    logic [NL-1:0] err_v;

    // Expected results of the first calibration run, lane 0 first.
    logic [TW-1:0] exp_a [NL] = '{5'd15, 5'd15, 5'd23, 5'd3, 5'd0, 5'd0, 5'd22, 5'd29};

    always #5 clk = ~clk;

    adc_lane_deskew dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_rise   (data_rise),
        .data_fall   (data_fall),
        .exp_rise    (exp_rise),
        .exp_fall    (exp_fall),
        .delay_ld    (delay_ld),
        .delay_wdata (delay_wdata),
        .tap_out     (tap_out),
        .lane_fail   (lane_fail),
        .busy        (busy),
        .done        (done)
    );

    // Lane model: a failing tap corrupts rise on even lanes, fall on odd lanes.
    always_comb begin
        err_v = '0;
        for (int i = 0; i < NL; i++) begin
            err_v[i] = ~mask[i][cur_tap[i]];
            if (inj_en && i == 6 && cur_tap[i] == 5'd12 && scnt[i] == 66)
                err_v[i] = 1'b1;
        end
    end
    assign data_rise = exp_rise ^ (err_v & 8'h55);
    assign data_fall = exp_fall ^ (err_v & 8'hAA);

    // IODELAY model: latch CNTVALUEIN on load, count cycles since the load.
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (delay_ld[i]) begin
                cur_tap[i] <= delay_wdata;
                scnt[i]    <= 0;
                ld_cnt[i]  <= ld_cnt[i] + 1;
            end else begin
                scnt[i] <= scnt[i] + 1;
            end
        end
        if ($countones(delay_ld) > 1)
            onehot_bad <= onehot_bad + 1;
        if ((delay_ld & prev_ld) != '0)
            hold_bad <= hold_bad + 1;
        prev_ld <= delay_ld;
    end

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        total += 6;
        if (delay_ld !== 8'h00) begin bad++; $display("FAIL reset_delay_ld: got %0h want 0", delay_ld); end
        if (delay_wdata !== 5'd0) begin bad++; $display("FAIL reset_delay_wdata: got %0h want 0", delay_wdata); end
        if (tap_out !== 40'd0) begin bad++; $display("FAIL reset_tap_out: got %0h want 0", tap_out); end
        if (lane_fail !== 8'h00) begin bad++; $display("FAIL reset_lane_fail: got %0h want 0", lane_fail); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total += 2;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL idle_done: got %0b want 0", done); end
        $display("test_reset: checks so far %0d, bad %0d", total, bad);
    endtask

    task automatic test_calibration();
        int n;
        bit got;
        int ld0 [NL];
        int oh0, hb0;
        mask[0] = 32'hFFFF_FFFF;   // all taps pass
        mask[1] = 32'h001F_FC00;   // 10..20
        mask[2] = 32'h0FF0_01F8;   // 3..8 and 20..27
        mask[3] = 32'h0000_3C3C;   // 2..5 and 10..13, equal length
        mask[4] = 32'h0000_0007;   // 0..2, too short
        mask[5] = 32'h0000_0000;   // never passes
        mask[6] = 32'hFFFF_FFFF;   // single error at tap 12, last sample
        mask[7] = 32'hF000_0000;   // 28..31, open at max tap
        inj_en = 1'b1;
        for (int i = 0; i < NL; i++) ld0[i] = ld_cnt[i];
        oh0 = onehot_bad;
        hb0 = hold_bad;
        start = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < LAT + 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) start = 1'b0;
            if (n == 3000) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL midsweep_busy: got %0b want 1", busy); end
                start = 1'b1;
            end
            if (n == 3001) start = 1'b0;
            if (done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got || n != LAT) begin bad++; $display("FAIL cal_latency: got %0d (done=%0b) want %0d", n, got, LAT); end
        for (int i = 0; i < NL; i++) begin
            total += 3;
            if (tap_out[i*TW +: TW] !== exp_a[i]) begin
                bad++; $display("FAIL cal_tap_out lane%0d: got %0d want %0d", i, tap_out[i*TW +: TW], exp_a[i]);
            end
            if (cur_tap[i] !== exp_a[i]) begin
                bad++; $display("FAIL cal_loaded_tap lane%0d: got %0d want %0d", i, cur_tap[i], exp_a[i]);
            end
            if (ld_cnt[i] - ld0[i] != 33) begin
                bad++; $display("FAIL cal_ld_count lane%0d: got %0d want 33", i, ld_cnt[i] - ld0[i]);
            end
        end
        total += 5;
        if (lane_fail !== 8'h30) begin bad++; $display("FAIL cal_lane_fail: got %0h want 30", lane_fail); end
        if (busy !== 1'b0) begin bad++; $display("FAIL cal_busy: got %0b want 0", busy); end
        if (done !== 1'b1) begin bad++; $display("FAIL cal_done: got %0b want 1", done); end
        if (onehot_bad != oh0) begin bad++; $display("FAIL cal_ld_onehot: got %0d violations want 0", onehot_bad - oh0); end
        if (hold_bad != hb0) begin bad++; $display("FAIL cal_ld_width: got %0d long pulses want 0", hold_bad - hb0); end
        $display("test_calibration: cycles %0d, checks so far %0d, bad %0d", n, total, bad);
    endtask

    task automatic test_restart_abort();
        logic [NL*TW-1:0] exp_flat;
        bit seen;
        for (int i = 0; i < NL; i++) exp_flat[i*TW +: TW] = exp_a[i];
        for (int i = 0; i < NL; i++) mask[i] = 32'hFFFF_FFFF;
        mask[5] = 32'h0;
        inj_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total += 4;
        if (done !== 1'b0) begin bad++; $display("FAIL restart_done: got %0b want 0", done); end
        if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy: got %0b want 1", busy); end
        if (lane_fail !== 8'h00) begin bad++; $display("FAIL restart_lane_fail: got %0h want 0", lane_fail); end
        if (tap_out !== exp_flat) begin bad++; $display("FAIL restart_tap_hold: got %0h want %0h", tap_out, exp_flat); end
        repeat (4000) @(posedge clk);
        #1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (delay_ld != '0) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL abort_ld_seen: got none within 200 cycles want a load pulse"); end
        rst = 1'b0;
        #1;
        total += 6;
        if (delay_ld !== 8'h00) begin bad++; $display("FAIL abort_delay_ld: got %0h want 0", delay_ld); end
        if (delay_wdata !== 5'd0) begin bad++; $display("FAIL abort_delay_wdata: got %0h want 0", delay_wdata); end
        if (tap_out !== 40'd0) begin bad++; $display("FAIL abort_tap_out: got %0h want 0", tap_out); end
        if (lane_fail !== 8'h00) begin bad++; $display("FAIL abort_lane_fail: got %0h want 0", lane_fail); end
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b want 0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %0b want 0", done); end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("test_restart_abort: checks so far %0d, bad %0d", total, bad);
    endtask

    task automatic test_after_reset();
        int n;
        bit got;
        logic [TW-1:0] want;
        start = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < LAT + 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                start = 1'b0;
                total += 2;
                if (busy !== 1'b1) begin bad++; $display("FAIL rerun_busy: got %0b want 1", busy); end
                if (tap_out !== 40'd0) begin bad++; $display("FAIL rerun_tap_start: got %0h want 0", tap_out); end
            end
            if (n == 2300) begin
                total++;
                if (tap_out !== 40'd15) begin bad++; $display("FAIL rerun_tap_partial: got %0h want f", tap_out); end
            end
            if (done === 1'b1) got = 1'b1;
        end
        total += 2;
        if (!got || n != LAT) begin bad++; $display("FAIL rerun_latency: got %0d (done=%0b) want %0d", n, got, LAT); end
        if (lane_fail !== 8'h20) begin bad++; $display("FAIL rerun_lane_fail: got %0h want 20", lane_fail); end
        for (int i = 0; i < NL; i++) begin
            want = (i == 5) ? 5'd0 : 5'd15;
            total++;
            if (tap_out[i*TW +: TW] !== want) begin
                bad++; $display("FAIL rerun_tap_out lane%0d: got %0d want %0d", i, tap_out[i*TW +: TW], want);
            end
        end
        $display("test_after_reset: cycles %0d, checks so far %0d, bad %0d", n, total, bad);
    endtask

    initial begin
        test_reset();
        test_calibration();
        test_restart_abort();
        test_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
